// File: rtl/cpu_bus_bridge_pkg.sv
// Shared types and lane helpers for the CPU bus bridge and the load/store unit.
package cpu_bus_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAM_ISSUE = 3'd1,
    ST_RAM_DATA  = 3'd2,
    ST_IO_WAIT   = 3'd3,
    ST_RESP      = 3'd4
  } state_e;

  localparam logic [2:0] BHW_B = 3'b001;
  localparam logic [2:0] BHW_H = 3'b010;
  localparam logic [2:0] BHW_W = 3'b100;

  // Byte enables for an access of size bhw at byte offset off.
  function automatic logic [3:0] be_gen(input logic [2:0] bhw, input logic [1:0] off);
    logic [3:0] be;
    case (bhw)
      BHW_B:   be = 4'b0001 << off;
      BHW_H:   be = 4'b0011 << off;
      BHW_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Move right-justified store data onto its byte lanes.
  function automatic logic [31:0] wshift(input logic [31:0] data, input logic [1:0] off);
    return data << {off, 3'b000};
  endfunction

  // Right-justify and zero-extend the addressed bytes of a read word.
  function automatic logic [31:0] rextract(input logic [31:0] rword, input logic [1:0] off,
                                           input logic [2:0] bhw);
    logic [31:0] sh;
    logic [31:0] r;
    sh = rword >> {off, 3'b000};
    case (bhw)
      BHW_B:   r = {24'h0, sh[7:0]};
      BHW_H:   r = {16'h0, sh[15:0]};
      BHW_W:   r = sh;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_bus_bridge_if.sv
// CPU, RAM and IO signals of the bridge. slave = bridge side, master = environment side.
interface cpu_bus_bridge_if #(
  parameter int RAM_AW = 14
);
  logic [31:0]       i_bus_address;
  logic [31:0]       i_bus_data;
  logic              i_bus_DV;
  logic [2:0]        i_bhw;
  logic              i_write_notread;
  logic [31:0]       o_bus_data;
  logic              o_bus_DV;
  logic              o_bus_err;

  logic              o_ram_en;
  logic              o_ram_we;
  logic [RAM_AW-1:0] o_ram_addr;
  logic [3:0]        o_ram_be;
  logic [31:0]       o_ram_wdata;
  logic [31:0]       i_ram_rdata;

  logic              o_io_req;
  logic              o_io_we;
  logic [31:0]       o_io_addr;
  logic [3:0]        o_io_be;
  logic [31:0]       o_io_wdata;
  logic              i_io_ack;
  logic [31:0]       i_io_rdata;

  modport slave (
    input  i_bus_address, i_bus_data, i_bus_DV, i_bhw, i_write_notread,
    input  i_ram_rdata, i_io_ack, i_io_rdata,
    output o_bus_data, o_bus_DV, o_bus_err,
    output o_ram_en, o_ram_we, o_ram_addr, o_ram_be, o_ram_wdata,
    output o_io_req, o_io_we, o_io_addr, o_io_be, o_io_wdata
  );

  modport master (
    output i_bus_address, i_bus_data, i_bus_DV, i_bhw, i_write_notread,
    output i_ram_rdata, i_io_ack, i_io_rdata,
    input  o_bus_data, o_bus_DV, o_bus_err,
    input  o_ram_en, o_ram_we, o_ram_addr, o_ram_be, o_ram_wdata,
    input  o_io_req, o_io_we, o_io_addr, o_io_be, o_io_wdata
  );
endinterface

// File: rtl/cpu_bus_bridge_bus_lane_align.sv
// Combinational byte-lane alignment: byte enables, store data shift, load data extract.
module bus_lane_align
  import cpu_bus_bridge_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_bhw,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  // Lane mapping for the latched request.
  always_comb begin
    o_be    = be_gen(i_bhw, i_off);
    o_wdata = wshift(i_wdata, i_off);
    o_rdata = rextract(i_rword, i_off, i_bhw);
  end

endmodule

// File: rtl/cpu_bus_bridge.sv
// Single-outstanding bridge from the CPU memory bus to on-chip RAM and handshaked IO.
//
// state        | meaning
// ST_IDLE      | waiting for i_bus_DV; request latched and decoded
// ST_RAM_ISSUE | one-cycle o_ram_en; stores complete here
// ST_RAM_DATA  | RAM read word valid; aligned and captured
// ST_IO_WAIT   | o_io_req held until ack or timeout
// ST_RESP      | one-cycle o_bus_DV; data/err held afterwards
module cpu_bus_bridge
  import cpu_bus_bridge_pkg::*;
#(
  parameter int          RAM_AW     = 14,
  parameter logic [31:0] IO_BASE    = 32'h1000_0000,
  parameter int          IO_TIMEOUT = 255
) (
  input logic             i_clk,
  input logic             i_rst_n,
  cpu_bus_bridge_if.slave bus
);

  localparam int TO_W = ($clog2(IO_TIMEOUT + 1) > 8) ? $clog2(IO_TIMEOUT + 1) : 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(IO_TIMEOUT - 1);
  localparam logic [32:0] RAM_END = 33'(4) << RAM_AW;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        bhw_q, bhw_d;
  logic              we_q, we_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_misalign, req_ram, req_io, req_err;
  logic              ram_act, io_act;
  logic [3:0]        ram_be, io_be;
  logic [31:0]       ram_wdata, io_wdata, ram_rdata_al, io_rdata_al;

  assign req_misalign = ((bus.i_bhw == BHW_H) && bus.i_bus_address[0]) ||
                        ((bus.i_bhw == BHW_W) && (bus.i_bus_address[1:0] != 2'b00));
  assign req_ram      = ({1'b0, bus.i_bus_address} < RAM_END);
  assign req_io       = (bus.i_bus_address >= IO_BASE);
  assign req_err      = !$onehot(bus.i_bhw) || req_misalign || !(req_ram || req_io);

  bus_lane_align u_ram_align (
    .i_off   (addr_q[1:0]),
    .i_bhw   (bhw_q),
    .i_wdata (data_q),
    .i_rword (bus.i_ram_rdata),
    .o_be    (ram_be),
    .o_wdata (ram_wdata),
    .o_rdata (ram_rdata_al)
  );

  bus_lane_align u_io_align (
    .i_off   (addr_q[1:0]),
    .i_bhw   (bhw_q),
    .i_wdata (data_q),
    .i_rword (bus.i_io_rdata),
    .o_be    (io_be),
    .o_wdata (io_wdata),
    .o_rdata (io_rdata_al)
  );

  // Next-state, request latching and response capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bhw_d   = bhw_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_bus_DV) begin
          addr_d = bus.i_bus_address;
          data_d = bus.i_bus_data;
          bhw_d  = bus.i_bhw;
          we_d   = bus.i_write_notread;
          if (req_err) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (req_ram) begin
            state_d = ST_RAM_ISSUE;
          end else begin
            cnt_d   = '0;
            state_d = ST_IO_WAIT;
          end
        end
      end
      ST_RAM_ISSUE: begin
        if (we_q) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else begin
          state_d = ST_RAM_DATA;
        end
      end
      ST_RAM_DATA: begin
        rdata_d = ram_rdata_al;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_IO_WAIT: begin
        // An ack in the final cycle wins over the timeout.
        if (bus.i_io_ack) begin
          rdata_d = we_q ? '0 : io_rdata_al;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset drops any transaction in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      bhw_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bhw_q   <= bhw_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory-side outputs are gated by state so they read as zero outside their phase.
  assign ram_act = (state_q == ST_RAM_ISSUE);
  assign io_act  = (state_q == ST_IO_WAIT);

  assign bus.o_bus_DV    = (state_q == ST_RESP);
  assign bus.o_bus_data  = rdata_q;
  assign bus.o_bus_err   = err_q;

  assign bus.o_ram_en    = ram_act;
  assign bus.o_ram_we    = ram_act & we_q;
  assign bus.o_ram_addr  = ram_act ? addr_q[RAM_AW+1:2] : '0;
  assign bus.o_ram_be    = ram_act ? ram_be : '0;
  assign bus.o_ram_wdata = (ram_act && we_q) ? ram_wdata : '0;

  assign bus.o_io_req    = io_act;
  assign bus.o_io_we     = io_act & we_q;
  assign bus.o_io_addr   = io_act ? addr_q : '0;
  assign bus.o_io_be     = io_act ? io_be : '0;
  assign bus.o_io_wdata  = (io_act && we_q) ? io_wdata : '0;

endmodule

// File: doc/cpu_bus_bridge.md
# cpu_bus_bridge

Single-outstanding bus bridge between the CPU core's memory bus and the system's memory and peripherals. It latches the CPU's one-cycle request pulse, checks alignment, and decodes the address to an on-chip RAM port or a handshaked IO port. It generates byte enables and lane-shifted write data, right-justifies read data, and returns a one-cycle data-valid pulse, with an error flag where the access fails. Sign extension of loads stays in the CPU's load/store unit; the bridge returns zero-extended data.

## Interface
- RAM_AW, 14: RAM word-address width (RAM spans byte addresses 0 .. 4·2^RAM_AW−1).
- IO_BASE, 32'h1000_0000: first IO byte address; IO spans IO_BASE .. 32'hFFFF_FFFF.
- IO_TIMEOUT, 255: maximum number of cycles to wait for i_io_ack.

- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_bus_address  in  32  CPU byte address.
- i_bus_data  in  32  CPU write data, right-justified.
- i_bus_DV  in  1  one-cycle request strobe.
- i_bhw  in  3  access size, one-hot: 001 byte, 010 half, 100 word.
- i_write_notread  in  1  1 = store, 0 = load.
- o_bus_data  out  32  load data, right-justified and zero-extended.
- o_bus_DV  out  1  one-cycle completion strobe, for both loads and stores.
- o_bus_err  out  1  high together with o_bus_DV on an errored access.
- o_ram_en, o_ram_we  out  1  RAM access strobe and write enable.
- o_ram_addr  out  RAM_AW  RAM word address.
- o_ram_be  out  4  RAM byte enables.
- o_ram_wdata  out  32  RAM lane-shifted write data.
- i_ram_rdata  in  32  RAM read word, valid the cycle after o_ram_en.
- o_io_req  out  1  IO request, held high until i_io_ack or timeout.
- o_io_we  out  1  IO write enable.
- o_io_addr  out  32  IO byte address.
- o_io_be  out  4  IO byte enables.
- o_io_wdata  out  32  IO lane-shifted write data.
- i_io_ack  in  1  IO completion.
- i_io_rdata  in  32  IO read word, valid with i_io_ack.

## Operation
- States: IDLE, RAM_ISSUE, RAM_DATA, IO_WAIT, RESP.
- **IDLE**
  - When i_bus_DV is high, register the address, data, size and direction.
  - Decode the request and go to RAM_ISSUE, IO_WAIT or RESP (RESP for errors).
- **Error conditions** (go straight to RESP with err=1, no memory access):
  - i_bhw not one-hot;
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - address ≥ 4·2^RAM_AW and < IO_BASE.
- **Lanes** (off = addr[1:0])
  - be = 0001<<off for a byte, 0011<<off for a half, 1111 for a word.
  - wdata = data << 8·off.
  - Read result = (rword >> 8·off) masked to the access size.
- **RAM_ISSUE**
  - o_ram_en=1 for one cycle; o_ram_addr = addr[RAM_AW+1:2].
  - Stores go to RESP; loads go to RAM_DATA.
- **RAM_DATA**: capture and shift i_ram_rdata, then go to RESP.
- **IO_WAIT**
  - o_io_req stays high and all IO outputs stay stable.
  - On i_io_ack: capture i_io_rdata and go to RESP.
  - If IO_TIMEOUT cycles pass without ack: data=0, err=1, go to RESP.
- **RESP**
  - o_bus_DV=1 for one cycle, then IDLE.
  - o_bus_data and o_bus_err hold their values until the next RESP.
- i_bus_DV outside IDLE is ignored. The CPU issues only one request at a time.

## Timing
- **Reset values**: state IDLE and every output 0, including o_bus_data, o_ram_*, o_io_* and o_bus_err. Reset takes effect immediately, mid-transaction included. Any pending request is dropped, and no o_bus_DV follows.
- **Latency**, with i_bus_DV sampled at edge T:
  - RAM load: o_bus_DV at T+3.
  - RAM store: o_bus_DV at T+2.
  - Error: o_bus_DV at T+1.
  - IO: o_bus_DV one cycle after the edge that samples i_io_ack.
- i_io_ack on the same cycle as the timeout expires counts as an ack; the access is not an error.
- The timeout counter is 8 bits or wider, cleared on entering IO_WAIT, and does not wrap.
- o_io_req drops in the cycle after ack is sampled.
- Neither o_ram_en nor o_io_req is ever asserted during RESP or IDLE.

## Structure
- Shared package holds:
  - state encoding constants;
  - size codes BHW_B/BHW_H/BHW_W;
  - the lane helper functions be_gen, wshift and rextract, which the load/store unit may also use.
- One natural sub-module, bus_lane_align: purely combinational be/wdata/rdata alignment, instantiated for both the RAM and IO paths.

## Test plan
- **RAM word store then load**:
  - Store 32'hCAFEBABE at 0x40: o_ram_be=1111 and o_bus_DV at T+2.
  - Load 0x40: o_bus_data=CAFEBABE at T+3.
- **Byte store 0xA5 at 0x43**: o_ram_be=1000, o_ram_wdata=A5000000. Byte load of 0x43 returns 32'h000000A5.
- **Half load at 0x42, RAM word 0x8001_1234**: returns 32'h00008001.
- **Misaligned accesses**:
  - Word load at 0x41: o_bus_DV and o_bus_err at T+1, o_ram_en never high.
  - The same for an address in the RAM–IO hole.
- **IO load at IO_BASE+4**:
  - With ack after 5 cycles carrying rdata 0x55: returns 0x55, err=0.
  - With no ack: o_bus_DV and err=1, data 0, exactly IO_TIMEOUT cycles after entering IO_WAIT.
- **Reset and busy behaviour**:
  - i_rst_n low in RAM_DATA: all outputs 0 at once, no o_bus_DV.
  - i_bus_DV while in IO_WAIT is ignored.
